// File: rtl/exec_sequencer_if.sv
// -----------------------------------------------------------------------------
// exec_sequencer_if
// Bundles the decoded-instruction inputs and the control strobes exchanged
// between the core top level and the execution sequencer.
//   master : core top level (drives run/decoded fields, consumes strobes)
//   slave  : exec_sequencer (consumes decoded fields, drives pc/strobes)
// Signals:
//   run      1 = execute continuously, 0 = stop at next instruction boundary
//   flag     decoded class (0 nop, 1 alu/branch, 2 move, 3 memory)
//   oper     decoded operation code
//   mem_op   decoded memory op (1 load, 2 store reg, 3 store imm)
//   intermed immediate field, low bits used as branch target
//   cmp_eq   reg_file[regA] == reg_file[regB]
//   pc       program counter to instr_mem
//   fetch_en, alu_en, opb_sel, we, mem_dsel, rf_we, rf_wsel, rf_wdst,
//   out_en, busy, illegal : control strobes / selects
// -----------------------------------------------------------------------------
interface exec_sequencer_if #(
  parameter int unsigned PC_W = 8
);
  logic            run;
  logic [1:0]      flag;
  logic [3:0]      oper;
  logic [1:0]      mem_op;
  logic [PC_W-1:0] intermed;
  logic            cmp_eq;

  logic [PC_W-1:0] pc;
  logic            fetch_en;
  logic            alu_en;
  logic            opb_sel;
  logic            we;
  logic            mem_dsel;
  logic            rf_we;
  logic [1:0]      rf_wsel;
  logic            rf_wdst;
  logic            out_en;
  logic            busy;
  logic            illegal;

  modport master (
    output run, flag, oper, mem_op, intermed, cmp_eq,
    input  pc, fetch_en, alu_en, opb_sel, we, mem_dsel,
           rf_we, rf_wsel, rf_wdst, out_en, busy, illegal
  );

  modport slave (
    input  run, flag, oper, mem_op, intermed, cmp_eq,
    output pc, fetch_en, alu_en, opb_sel, we, mem_dsel,
           rf_we, rf_wsel, rf_wdst, out_en, busy, illegal
  );
endinterface

// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
// Multi-cycle control FSM for the 16-bit core. Owns the program counter and
// sequences fetch, decode wait, ALU execute, data-memory access and
// register-file writeback.
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   seq_if  exec_sequencer_if.slave : decoded fields in, pc/strobes out
// Parameters:
//   PC_W     program counter width (pc wraps modulo 2^PC_W)
//   RESET_PC pc value loaded on reset
// Cycle cost, FETCH to next FETCH: nop/move/store/branch 4, ALU 5, load 6.
// -----------------------------------------------------------------------------
module exec_sequencer #(
  parameter int unsigned          PC_W     = 8,
  parameter logic [PC_W-1:0]      RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  exec_sequencer_if.slave  seq_if
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
  } state_e;

  state_e          state_q, state_d;
  logic            dec_wait_q, dec_wait_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;

  // Select values captured in EXEC and held through MEM/WB
  logic            opb_q, opb_d;
  logic            dsel_q, dsel_d;
  logic [1:0]      wsel_q, wsel_d;
  logic            wdst_q, wdst_d;

  // EXEC-state decode of the registered decoder fields
  logic            ex_alu, ex_opb, ex_we, ex_dsel, ex_rfwe, ex_wdst, ex_oen, ex_ill;
  logic [1:0]      ex_wsel;
  logic            ex_to_wb, ex_to_mem;
  logic [PC_W-1:0] ex_pc;

  // Output drivers
  logic            fetch_en_o, alu_en_o, opb_sel_o, we_o, mem_dsel_o;
  logic            rf_we_o, rf_wdst_o, out_en_o, busy_o, illegal_o;
  logic [1:0]      rf_wsel_o;

  assign pc_inc = pc_q + PC_W'(1);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      dec_wait_q <= 1'b0;
      pc_q       <= RESET_PC;
      opb_q      <= 1'b0;
      dsel_q     <= 1'b0;
      wsel_q     <= '0;
      wdst_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      dec_wait_q <= dec_wait_d;
      pc_q       <= pc_d;
      opb_q      <= opb_d;
      dsel_q     <= dsel_d;
      wsel_q     <= wsel_d;
      wdst_q     <= wdst_d;
    end
  end

  // ---------------------------------------------------------------------------
  // EXEC decode: what the current instruction does in its EXEC cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    ex_alu    = 1'b0;
    ex_opb    = 1'b0;
    ex_we     = 1'b0;
    ex_dsel   = 1'b0;
    ex_rfwe   = 1'b0;
    ex_wsel   = 2'd0;
    ex_wdst   = 1'b0;
    ex_oen    = 1'b0;
    ex_ill    = 1'b0;
    ex_to_wb  = 1'b0;
    ex_to_mem = 1'b0;
    ex_pc     = pc_inc;
    unique case (seq_if.flag)
      2'd0: begin
        // nop: default pc+1
      end
      2'd1: begin
        unique case (seq_if.oper)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            ex_alu   = 1'b1;
            ex_to_wb = 1'b1;
          end
          4'h6, 4'h7, 4'h8, 4'h9, 4'hB: begin
            ex_alu   = 1'b1;
            ex_opb   = 1'b1;
            ex_to_wb = 1'b1;
          end
          4'hA: begin
            ex_alu   = 1'b1;
            ex_wdst  = 1'b1;
            ex_to_wb = 1'b1;
          end
          4'hC: ex_pc = seq_if.cmp_eq ? seq_if.intermed : pc_inc;
          4'hD: ex_pc = seq_if.cmp_eq ? pc_inc : seq_if.intermed;
          4'hF: ex_pc = seq_if.intermed;
          default: ex_ill = 1'b1;   // 0 and E
        endcase
      end
      2'd2: begin
        unique case (seq_if.oper)
          4'h2: begin
            ex_rfwe = 1'b1;
            ex_wsel = 2'd1;
            ex_oen  = 1'b1;
          end
          4'h3: begin
            ex_rfwe = 1'b1;
            ex_wsel = 2'd2;
            ex_oen  = 1'b1;
          end
          default: ex_ill = 1'b1;
        endcase
      end
      2'd3: begin
        unique case (seq_if.mem_op)
          2'd1: begin
            ex_wsel   = 2'd3;
            ex_to_mem = 1'b1;
          end
          2'd2: ex_we = 1'b1;
          2'd3: begin
            ex_we   = 1'b1;
            ex_dsel = 1'b1;
          end
          default: ex_ill = 1'b1;
        endcase
      end
      default: ex_ill = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    dec_wait_d = 1'b0;
    pc_d       = pc_q;
    opb_d      = opb_q;
    dsel_d     = dsel_q;
    wsel_d     = wsel_q;
    wdst_d     = wdst_q;
    unique case (state_q)
      S_IDLE: begin
        if (seq_if.run) state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
        opb_d   = 1'b0;
        dsel_d  = 1'b0;
        wsel_d  = '0;
        wdst_d  = 1'b0;
      end
      S_DECODE: begin
        // Two cycles: instr_mem read latency, then the registered decoder.
        if (dec_wait_q) begin
          state_d = S_EXEC;
        end else begin
          dec_wait_d = 1'b1;
        end
      end
      S_EXEC: begin
        opb_d  = ex_opb;
        dsel_d = ex_dsel;
        wsel_d = ex_wsel;
        wdst_d = ex_wdst;
        if (ex_to_mem) begin
          state_d = S_MEM;
        end else if (ex_to_wb) begin
          state_d = S_WB;
        end else begin
          pc_d    = ex_pc;
          state_d = seq_if.run ? S_FETCH : S_IDLE;
        end
      end
      S_MEM: begin
        state_d = S_WB;
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = seq_if.run ? S_FETCH : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic (state-decoded; decoder fields are stable throughout EXEC)
  // ---------------------------------------------------------------------------
  always_comb begin
    fetch_en_o = 1'b0;
    alu_en_o   = 1'b0;
    opb_sel_o  = 1'b0;
    we_o       = 1'b0;
    mem_dsel_o = 1'b0;
    rf_we_o    = 1'b0;
    rf_wsel_o  = 2'd0;
    rf_wdst_o  = 1'b0;
    out_en_o   = 1'b0;
    illegal_o  = 1'b0;
    busy_o     = (state_q != S_IDLE);
    unique case (state_q)
      S_FETCH: fetch_en_o = 1'b1;
      S_EXEC: begin
        alu_en_o   = ex_alu;
        opb_sel_o  = ex_opb;
        we_o       = ex_we;
        mem_dsel_o = ex_dsel;
        rf_we_o    = ex_rfwe;
        rf_wsel_o  = ex_wsel;
        rf_wdst_o  = ex_wdst;
        out_en_o   = ex_oen;
        illegal_o  = ex_ill;
      end
      S_MEM: begin
        opb_sel_o  = opb_q;
        mem_dsel_o = dsel_q;
        rf_wsel_o  = wsel_q;
        rf_wdst_o  = wdst_q;
      end
      S_WB: begin
        rf_we_o    = 1'b1;
        out_en_o   = 1'b1;
        opb_sel_o  = opb_q;
        mem_dsel_o = dsel_q;
        rf_wsel_o  = wsel_q;
        rf_wdst_o  = wdst_q;
      end
      default: begin
      end
    endcase
  end

  assign seq_if.pc       = pc_q;
  assign seq_if.fetch_en = fetch_en_o;
  assign seq_if.alu_en   = alu_en_o;
  assign seq_if.opb_sel  = opb_sel_o;
  assign seq_if.we       = we_o;
  assign seq_if.mem_dsel = mem_dsel_o;
  assign seq_if.rf_we    = rf_we_o;
  assign seq_if.rf_wsel  = rf_wsel_o;
  assign seq_if.rf_wdst  = rf_wdst_o;
  assign seq_if.out_en   = out_en_o;
  assign seq_if.busy     = busy_o;
  assign seq_if.illegal  = illegal_o;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
// Directed self-checking bench for exec_sequencer. Each task starts with the
// DUT in a FETCH cycle (sampled 1 ns after the clock edge) and leaves it in the
// next FETCH cycle. Strobes are packed as
//   {fetch_en, alu_en, opb_sel, we, mem_dsel, rf_we, rf_wsel[1:0],
//    rf_wdst, out_en, busy, illegal}
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

  localparam logic [11:0] S_ID = 12'h000;  // idle / reset
  localparam logic [11:0] S_FE = 12'h802;  // fetch
  localparam logic [11:0] S_BZ = 12'h002;  // busy, no strobes

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exec_sequencer_if #(.PC_W(8)) sif ();

  exec_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .seq_if (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] strobes();
    return {sif.fetch_en, sif.alu_en, sif.opb_sel, sif.we, sif.mem_dsel,
            sif.rf_we, sif.rf_wsel, sif.rf_wdst, sif.out_en, sif.busy, sif.illegal};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    sif.run      = 1'b0;
    sif.flag     = 2'd0;
    sif.oper     = 4'h0;
    sif.mem_op   = 2'd0;
    sif.intermed = 8'h00;
    sif.cmp_eq   = 1'b0;
    #3;
    checks++;
    if (strobes() !== S_ID || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL reset_hold: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_ID, 8'h00);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (strobes() !== S_ID || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL idle_no_run: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_ID, 8'h00);
    end
  endtask

  task automatic test_nop();
    logic [11:0] es [4];
    logic [7:0]  ep [4];
    es = '{S_BZ, S_BZ, S_BZ, S_FE};
    ep = '{8'h00, 8'h00, 8'h00, 8'h01};
    sif.run  = 1'b1;
    sif.flag = 2'd0;
    tick();
    checks++;
    if (strobes() !== S_FE || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL nop_first_fetch: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_FE, 8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (strobes() !== es[i] || sif.pc !== ep[i]) begin
        errors++;
        $display("FAIL nop_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", i, strobes(), sif.pc, es[i], ep[i]);
      end
    end
  endtask

  task automatic test_alu();
    logic [3:0]  op [3];
    logic [11:0] es [3][5];
    logic [7:0]  pcx;
    logic [7:0]  ep;
    op = '{4'h1, 4'hA, 4'h6};
    es = '{'{S_BZ, S_BZ, 12'h402, 12'h046, S_FE},   // ADD
           '{S_BZ, S_BZ, 12'h40A, 12'h04E, S_FE},   // NOT: rf_wdst=1
           '{S_BZ, S_BZ, 12'h602, 12'h246, S_FE}};  // SHR: opb_sel=1
    pcx = 8'h01;
    for (int v = 0; v < 3; v++) begin
      sif.flag = 2'd1;
      sif.oper = op[v];
      for (int s = 0; s < 5; s++) begin
        tick();
        ep = (s == 4) ? pcx + 8'h01 : pcx;
        checks++;
        if (strobes() !== es[v][s] || sif.pc !== ep) begin
          errors++;
          $display("FAIL alu_op%h_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", op[v], s, strobes(), sif.pc, es[v][s], ep);
        end
      end
      pcx = pcx + 8'h01;
    end
  endtask

  task automatic test_branch();
    logic [1:0] fl  [8];
    logic [3:0] op  [8];
    logic [7:0] imm [8];
    logic       eq  [8];
    logic [7:0] tgt [8];
    logic [7:0] pcx;
    logic [11:0] exs;
    logic [7:0]  exp;
    fl  = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd0};
    op  = '{4'hC, 4'hC, 4'hD, 4'hD, 4'hF, 4'hF, 4'hF, 4'h0};
    imm = '{8'h40, 8'h40, 8'h10, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
    eq  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tgt = '{8'h40, 8'h41, 8'h42, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00};
    pcx = 8'h04;
    for (int v = 0; v < 8; v++) begin
      sif.flag     = fl[v];
      sif.oper     = op[v];
      sif.intermed = imm[v];
      sif.cmp_eq   = eq[v];
      for (int s = 0; s < 4; s++) begin
        tick();
        exs = (s == 3) ? S_FE : S_BZ;
        exp = (s == 3) ? tgt[v] : pcx;
        checks++;
        if (strobes() !== exs || sif.pc !== exp) begin
          errors++;
          $display("FAIL branch_v%0d_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", v, s, strobes(), sif.pc, exs, exp);
        end
      end
      pcx = tgt[v];
    end
  endtask

  task automatic test_mem();
    logic [11:0] el [6];
    logic [7:0]  pl [6];
    logic [1:0]  mo [2];
    logic [11:0] ex [2];
    logic [7:0]  pcx;
    logic [11:0] exs;
    logic [7:0]  exp;
    el = '{S_BZ, S_BZ, 12'h032, 12'h032, 12'h076, S_FE};
    pl = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    sif.flag   = 2'd3;
    sif.mem_op = 2'd1;
    for (int s = 0; s < 6; s++) begin
      tick();
      checks++;
      if (strobes() !== el[s] || sif.pc !== pl[s]) begin
        errors++;
        $display("FAIL load_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", s, strobes(), sif.pc, el[s], pl[s]);
      end
    end
    mo  = '{2'd3, 2'd2};
    ex  = '{12'h182, 12'h102};
    pcx = 8'h01;
    for (int v = 0; v < 2; v++) begin
      sif.mem_op = mo[v];
      for (int s = 0; s < 4; s++) begin
        tick();
        exs = (s == 3) ? S_FE : (s == 2) ? ex[v] : S_BZ;
        exp = (s == 3) ? pcx + 8'h01 : pcx;
        checks++;
        if (strobes() !== exs || sif.pc !== exp) begin
          errors++;
          $display("FAIL store_mo%0d_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", mo[v], s, strobes(), sif.pc, exs, exp);
        end
      end
      pcx = pcx + 8'h01;
    end
  endtask

  task automatic test_illegal();
    logic [1:0]  fl [6];
    logic [3:0]  op [6];
    logic [1:0]  mo [6];
    logic [11:0] ex [6];
    logic [7:0]  pcx;
    logic [11:0] exs;
    logic [7:0]  exp;
    fl  = '{2'd1, 2'd1, 2'd2, 2'd3, 2'd2, 2'd2};
    op  = '{4'hE, 4'h0, 4'h0, 4'h0, 4'h3, 4'h2};
    mo  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
    ex  = '{12'h003, 12'h003, 12'h003, 12'h003, 12'h066, 12'h056};
    pcx = 8'h03;
    for (int v = 0; v < 6; v++) begin
      sif.flag   = fl[v];
      sif.oper   = op[v];
      sif.mem_op = mo[v];
      for (int s = 0; s < 4; s++) begin
        tick();
        exs = (s == 3) ? S_FE : (s == 2) ? ex[v] : S_BZ;
        exp = (s == 3) ? pcx + 8'h01 : pcx;
        checks++;
        if (strobes() !== exs || sif.pc !== exp) begin
          errors++;
          $display("FAIL illegal_v%0d_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", v, s, strobes(), sif.pc, exs, exp);
        end
      end
      pcx = pcx + 8'h01;
    end
  endtask

  task automatic test_run_drop();
    logic [11:0] es [6];
    logic [7:0]  ep [6];
    es = '{S_BZ, S_BZ, 12'h402, 12'h046, S_ID, S_ID};
    ep = '{8'h09, 8'h09, 8'h09, 8'h09, 8'h0A, 8'h0A};
    sif.flag = 2'd1;
    sif.oper = 4'h1;
    for (int s = 0; s < 6; s++) begin
      tick();
      if (s == 0) sif.run = 1'b0;
      checks++;
      if (strobes() !== es[s] || sif.pc !== ep[s]) begin
        errors++;
        $display("FAIL run_drop_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", s, strobes(), sif.pc, es[s], ep[s]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [11:0] es [5];
    es = '{S_FE, S_BZ, S_BZ, 12'h032, 12'h032};
    sif.run    = 1'b1;
    sif.flag   = 2'd3;
    sif.mem_op = 2'd1;
    for (int s = 0; s < 5; s++) begin
      tick();
      checks++;
      if (strobes() !== es[s] || sif.pc !== 8'h0A) begin
        errors++;
        $display("FAIL rstmid_step%0d: strobes=%h pc=%h expected strobes=%h pc=%h", s, strobes(), sif.pc, es[s], 8'h0A);
      end
    end
    // Now in MEM: assert reset between edges
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_ID || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_async: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_ID, 8'h00);
    end
    tick();
    checks++;
    if (strobes() !== S_ID || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_held: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_ID, 8'h00);
    end
    @(negedge clk);
    rst_n   = 1'b1;
    sif.run = 1'b0;
    tick();
    tick();
    checks++;
    if (strobes() !== S_ID || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_after: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_ID, 8'h00);
    end
    sif.run = 1'b1;
    tick();
    checks++;
    if (strobes() !== S_FE || sif.pc !== 8'h00) begin
      errors++;
      $display("FAIL rstmid_restart: strobes=%h pc=%h expected strobes=%h pc=%h", strobes(), sif.pc, S_FE, 8'h00);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_nop();
    test_alu();
    test_branch();
    test_mem();
    test_illegal();
    test_run_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
